stopwatch_up: RTL

- Count-up MM:SS stopwatch, the counterpart of the countdown timer: starts at 00:00 and increments once per second until stopped or saturated.
- Produces four BCD digits in the same order the countdown timer uses: bin0 = seconds units, bin3 = minutes tens.
- Digits feed the existing SegDisplay driver directly.
- Control inputs are single-cycle pulses from PushButton_Debouncer down-edge outputs in the clk domain.

---
 rtl/stopwatch_up.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_up.sv
// Count-up MM:SS stopwatch (00:00..59:59, saturating) with BCD digit outputs; optional lap hold under STOPWATCH_LAP_EN.
// Latency: digits update 1 clk after the tick cycle; running/done update 1 clk after the causing pulse.
// Backpressure: none; control inputs are single-cycle pulses and outputs are always valid.
module stopwatch_up #(
  parameter int TICK_DIV = 50000000,
  parameter int TICK_W   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] bin0,
  output logic [3:0] bin1,
  output logic [3:0] bin2,
  output logic [3:0] bin3,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Live count packed as {min tens, min units, sec tens, sec units}.
  localparam logic [15:0] SAT_CNT = 16'h5959;

  state_t            r_state;
  logic [TICK_W-1:0] r_presc;
  logic [15:0]       r_cnt;
  logic              r_running;
  logic              r_done;

  logic              w_tick;
  logic              w_sat;
  logic [15:0]       w_cnt_inc;
  logic [15:0]       w_cnt_nxt;

  assign w_tick = (r_state == S_RUN) && (r_presc == TICK_W'(TICK_DIV - 1));
  assign w_sat  = (r_cnt == SAT_CNT);

  // BCD ripple increment of the live count (saturation is handled by the caller).
  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt[3:0] == 4'd9) begin
      w_cnt_inc[3:0] = 4'd0;
      if (r_cnt[7:4] == 4'd5) begin
        w_cnt_inc[7:4] = 4'd0;
        if (r_cnt[11:8] == 4'd9) begin
          w_cnt_inc[11:8]  = 4'd0;
          w_cnt_inc[15:12] = r_cnt[15:12] + 4'd1;
        end else begin
          w_cnt_inc[11:8] = r_cnt[11:8] + 4'd1;
        end
      end else begin
        w_cnt_inc[7:4] = r_cnt[7:4] + 4'd1;
      end
    end else begin
      w_cnt_inc[3:0] = r_cnt[3:0] + 4'd1;
    end
  end

  // Next live count: clear wins, a tick coinciding with pause is dropped, 59:59 holds.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear) begin
      w_cnt_nxt = 16'h0000;
    end else if (w_tick && !start_stop && !w_sat) begin
      w_cnt_nxt = w_cnt_inc;
    end
  end

  // Control FSM with prescaler and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_cnt     <= 16'h0000;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (clear) begin
        r_state   <= S_IDLE;
        r_presc   <= '0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_stop) begin
              r_state   <= S_RUN;
              r_presc   <= '0;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            if (start_stop) begin
              // Pausing keeps the partial second unless this was the tick cycle.
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
              if (w_tick) begin
                r_presc <= '0;
              end
            end else if (w_tick) begin
              r_presc <= '0;
              if (w_sat) begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + TICK_W'(1);
            end
          end
          S_PAUSE: begin
            if (start_stop) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_DONE: begin
            // Only clear or reset leaves the saturated state.
          end
          default: begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign running = r_running;
  assign done    = r_done;

`ifdef STOPWATCH_LAP_EN
  logic        r_hold;
  logic [15:0] r_snap;
  logic [15:0] r_bin;
  logic        w_lap_ok;
  logic        w_hold_nxt;
  logic [15:0] w_snap_nxt;

  assign w_lap_ok = lap && !clear && ((r_state == S_RUN) || (r_state == S_PAUSE));

  // Lap hold toggle; the snapshot captures the displayed live count on hold entry.
  always_comb begin
    w_hold_nxt = r_hold;
    w_snap_nxt = r_snap;
    if (clear) begin
      w_hold_nxt = 1'b0;
    end else if (w_lap_ok) begin
      w_hold_nxt = ~r_hold;
      if (!r_hold) begin
        w_snap_nxt = r_cnt;
      end
    end
  end

  // Output digit registers select snapshot or live count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= 1'b0;
      r_snap <= 16'h0000;
      r_bin  <= 16'h0000;
    end else begin
      r_hold <= w_hold_nxt;
      r_snap <= w_snap_nxt;
      r_bin  <= w_hold_nxt ? w_snap_nxt : w_cnt_nxt;
    end
  end

  assign bin0 = r_bin[3:0];
  assign bin1 = r_bin[7:4];
  assign bin2 = r_bin[11:8];
  assign bin3 = r_bin[15:12];
`else
  // Lap is accepted on the port but has no function in this build.
  logic w_lap_unused;
  assign w_lap_unused = lap;

  assign bin0 = r_cnt[3:0];
  assign bin1 = r_cnt[7:4];
  assign bin2 = r_cnt[11:8];
  assign bin3 = r_cnt[15:12];
`endif

endmodule
